// File: rtl/spawn_scheduler_pkg.sv
// spawn_scheduler_pkg: shared types and constants for the spawn scheduler slice
package spawn_scheduler_pkg;
    localparam int POS_W = 5;
    localparam int POS_BASE = 9;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_REQ    = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_PUSH   = 3'd4
    } state_t;
endpackage

// File: rtl/spawn_fifo.sv
// spawn_fifo: DEPTH x W circular FIFO with separate occupancy count
module spawn_fifo import spawn_scheduler_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W = POS_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rd_en = pop & ~empty;
    // a full FIFO can still accept when the head leaves in the same cycle
    assign wr_en = push & (~full | rd_en);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces LFSR samples into a repeat-filtered stream of spawn positions
module spawn_scheduler import spawn_scheduler_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int MAX_RETRY = 2,
    parameter int INT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         tick,
    input  logic [INT_W-1:0]             interval,
    input  logic [POS_W-1:0]             col_range,
    output logic [POS_W-1:0]             rand_range,
    output logic                         rand_gen,
    input  logic [POS_W-1:0]             rand_in,
    output logic                         spawn_valid,
    output logic [POS_W-1:0]             spawn_pos,
    input  logic                         spawn_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         drop
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    state_t state, state_nx;
    logic [INT_W-1:0] timer, timer_nx, term;
    logic [RW-1:0] retry, retry_nx;
    logic [POS_W-1:0] last_pos, cand;
    logic push, pop, full, empty;
    assign rand_range = col_range;
    assign term = interval == '0 ? '0 : interval - INT_W'(1);
    assign rand_gen = state == ST_REQ;
    assign push = state == ST_PUSH;
    assign pop = spawn_valid & spawn_ready;
    assign spawn_valid = ~empty;
    assign drop = push & full & ~pop;
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        retry_nx = retry;
        case (state)
            ST_IDLE: begin
                timer_nx = '0;
                retry_nx = '0;
                state_nx = enable ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!enable) state_nx = ST_IDLE;
                else if (tick) begin
                    timer_nx = timer == term ? '0 : timer + INT_W'(1);
                    state_nx = timer == term ? ST_REQ : ST_WAIT;
                end
            end
            ST_REQ: begin
                retry_nx = enable ? retry : '0;
                state_nx = enable ? ST_SAMPLE : ST_IDLE;
            end
            ST_SAMPLE: begin
                if (!enable) begin
                    retry_nx = '0;
                    state_nx = ST_IDLE;
                end else if (rand_in == last_pos && retry < RW'(MAX_RETRY)) begin
                    retry_nx = retry + RW'(1);
                    state_nx = ST_REQ;
                end else state_nx = ST_PUSH;
            end
            ST_PUSH: begin
                retry_nx = '0;
                state_nx = enable ? ST_WAIT : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end
    // last_pos follows every completed push, even one the full FIFO drops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            timer <= '0;
            retry <= '0;
            last_pos <= '0;
            cand <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            retry <= retry_nx;
            cand <= state == ST_SAMPLE ? rand_in : cand;
            last_pos <= push ? cand : last_pos;
        end
    end
    spawn_fifo #(.DEPTH(DEPTH), .W(POS_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cand),
        .dout  (spawn_pos),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed checks of pacing, repeat rejection, FIFO and reset behaviour
module tb_spawn_scheduler;
    logic clk = 1'b0;
    logic rst, enable, tick, spawn_ready;
    logic [7:0] interval;
    logic [4:0] col_range, rand_range, spawn_pos;
    logic [4:0] rand_in = '0;
    logic rand_gen, spawn_valid, drop;
    logic [2:0] fifo_count;
    int cyc = 0;
    int vi = 0;
    int wi, n_vec, n_bad;
    int n_valid = 0;
    logic [4:0] vals [64];
    int rg_cyc[$], tick_cyc[$], drop_cyc[$], pop_cyc[$], pos_log[$];
    int s_rg, s_t, s_d, s_p, s_v;

    spawn_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .interval    (interval),
        .col_range   (col_range),
        .rand_range  (rand_range),
        .rand_gen    (rand_gen),
        .rand_in     (rand_in),
        .spawn_valid (spawn_valid),
        .spawn_pos   (spawn_pos),
        .spawn_ready (spawn_ready),
        .fifo_count  (fifo_count),
        .drop        (drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LFSR stand-in plus event log, sampled mid-cycle
    always @(negedge clk) begin
        if (rand_gen) begin
            rand_in <= vals[vi];
            vi <= vi + 1;
            rg_cyc.push_back(cyc);
        end
        if (tick) tick_cyc.push_back(cyc);
        if (drop) drop_cyc.push_back(cyc);
        if (spawn_valid) begin
            n_valid <= n_valid + 1;
            if (spawn_ready) begin
                pop_cyc.push_back(cyc);
                pos_log.push_back(int'(spawn_pos));
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    task automatic load(input int v);
        vals[wi] = 5'(v);
        wi++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            tick = (per == 0) ? 1'b0 : (i % per == per - 1);
            step();
        end
        tick = 1'b0;
    endtask

    task automatic snap();
        s_rg = rg_cyc.size();
        s_t = tick_cyc.size();
        s_d = drop_cyc.size();
        s_p = pos_log.size();
        s_v = n_valid;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; tick = 1'b0; interval = 8'd3; col_range = 5'd5; spawn_ready = 1'b1;
        n_vec = 0; n_bad = 0; wi = 0;
        repeat (3) step();
        chk("reset_rand_gen", rand_gen, 0);
        chk("reset_valid", spawn_valid, 0);
        chk("reset_pos", spawn_pos, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_drop", drop, 0);
        rst = 1'b1;
        step();
        chk("range_5", rand_range, 5);
        col_range = 5'd17;
        #1 chk("range_17", rand_range, 17);
        col_range = 5'd5;

        // pacing: interval 3, tick every 4 cycles
        load(12); load(15); load(9);
        snap();
        enable = 1'b1;
        run(45, 4);
        enable = 1'b0;
        run(2, 0);
        chk("pace_rg_count", rg_cyc.size() - s_rg, 3);
        chk("pace_rg_after_tick", qat(rg_cyc, s_rg) - qat(tick_cyc, s_t + 2), 1);
        chk("pace_rg_gap1", qat(rg_cyc, s_rg + 1) - qat(rg_cyc, s_rg), 12);
        chk("pace_rg_gap2", qat(rg_cyc, s_rg + 2) - qat(rg_cyc, s_rg + 1), 12);
        chk("pace_pos0", qat(pos_log, s_p), 12);
        chk("pace_pos1", qat(pos_log, s_p + 1), 15);
        chk("pace_pos2", qat(pos_log, s_p + 2), 9);
        chk("pace_valid_cycles", n_valid - s_v, 3);
        chk("pace_push_lat", qat(pop_cyc, s_p) - qat(rg_cyc, s_rg), 3);

        // repeat rejection: 14; then 14,14,14; then 14,11
        interval = 8'd1;
        load(14); load(14); load(14); load(14); load(14); load(11);
        snap();
        enable = 1'b1;
        run(19, 1);
        enable = 1'b0;
        run(2, 0);
        chk("rep_rg_count", rg_cyc.size() - s_rg, 6);
        chk("rep_gap0", qat(rg_cyc, s_rg + 1) - qat(rg_cyc, s_rg), 4);
        chk("rep_gap1", qat(rg_cyc, s_rg + 2) - qat(rg_cyc, s_rg + 1), 2);
        chk("rep_gap2", qat(rg_cyc, s_rg + 3) - qat(rg_cyc, s_rg + 2), 2);
        chk("rep_gap3", qat(rg_cyc, s_rg + 4) - qat(rg_cyc, s_rg + 3), 4);
        chk("rep_gap4", qat(rg_cyc, s_rg + 5) - qat(rg_cyc, s_rg + 4), 2);
        chk("rep_push_count", pos_log.size() - s_p, 3);
        chk("rep_pos0", qat(pos_log, s_p), 14);
        chk("rep_pos1", qat(pos_log, s_p + 1), 14);
        chk("rep_pos2", qat(pos_log, s_p + 2), 11);

        // FIFO fill and drop
        spawn_ready = 1'b0;
        load(9); load(10); load(11); load(12); load(13);
        snap();
        enable = 1'b1;
        run(21, 1);
        enable = 1'b0;
        run(2, 0);
        chk("full_rg_count", rg_cyc.size() - s_rg, 5);
        chk("full_drop_count", drop_cyc.size() - s_d, 1);
        chk("full_drop_at_5th", qat(drop_cyc, s_d) - qat(rg_cyc, s_rg + 4), 2);
        chk("full_count", fifo_count, 4);
        chk("full_head", spawn_pos, 9);
        chk("full_valid", spawn_valid, 1);

        // full FIFO with a pop in the PUSH cycle; 13 equals last_pos so it needs two re-rolls
        load(13); load(13); load(13);
        snap();
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick = 1'b1;
            spawn_ready = (i == 8);
            step();
        end
        enable = 1'b0;
        spawn_ready = 1'b0;
        run(2, 0);
        chk("fpop_rg_count", rg_cyc.size() - s_rg, 3);
        chk("fpop_no_drop", drop_cyc.size() - s_d, 0);
        chk("fpop_count", fifo_count, 4);
        chk("fpop_head", spawn_pos, 10);
        spawn_ready = 1'b1;
        run(6, 0);
        chk("fpop_drain_count", pos_log.size() - s_p, 5);
        chk("fpop_d0", qat(pos_log, s_p), 9);
        chk("fpop_d1", qat(pos_log, s_p + 1), 10);
        chk("fpop_d2", qat(pos_log, s_p + 2), 11);
        chk("fpop_d3", qat(pos_log, s_p + 3), 12);
        chk("fpop_tail", qat(pos_log, s_p + 4), 13);
        chk("fpop_empty_count", fifo_count, 0);

        // disable while in SAMPLE
        interval = 8'd2;
        load(20); load(21);
        snap();
        enable = 1'b1;
        run(4, 1);
        enable = 1'b0;
        run(3, 1);
        chk("dis_no_push", pos_log.size() - s_p, 0);
        chk("dis_count", fifo_count, 0);
        enable = 1'b1;
        run(7, 1);
        enable = 1'b0;
        run(2, 0);
        chk("dis_rg_count", rg_cyc.size() - s_rg, 2);
        chk("dis_rg_gap", qat(rg_cyc, s_rg + 1) - qat(rg_cyc, s_rg), 7);
        chk("dis_push_count", pos_log.size() - s_p, 1);
        chk("dis_pos", qat(pos_log, s_p), 21);

        // asynchronous reset while waiting with timer at 3 and one entry queued
        interval = 8'd1;
        spawn_ready = 1'b0;
        load(7); load(22);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick = (i != 4);
            if (i == 4) interval = 8'd5;
            step();
        end
        tick = 1'b0;
        chk("arst_pre_count", fifo_count, 1);
        rst = 1'b0;
        #1;
        chk("arst_rand_gen", rand_gen, 0);
        chk("arst_valid", spawn_valid, 0);
        chk("arst_pos", spawn_pos, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_drop", drop, 0);
        step();
        rst = 1'b1;
        snap();
        run(7, 1);
        enable = 1'b0;
        run(2, 0);
        chk("arst_rg_count", rg_cyc.size() - s_rg, 1);
        chk("arst_timer_restart", qat(rg_cyc, s_rg) - qat(tick_cyc, s_t), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Consumes random values from the upstream 5-bit LFSR stage and turns them into a paced stream of spawn positions for the game logic.
- On every spawn interval it requests one value and rejects an immediate repeat of the previous position, with bounded retries.
- Accepted positions go into a small FIFO, drained downstream with a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- MAX_RETRY, 2, re-rolls allowed when a sample equals the last accepted position.
- INT_W, 8, width of the interval counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- enable  input  1  scheduler run enable
- tick  input  1  one-cycle game-tick strobe; the only thing that advances the interval timer
- interval  input  INT_W  ticks between spawn requests; 0 is treated as 1
- col_range  input  5  number of legal positions, passed through to the LFSR
- rand_range  output  5  range to the LFSR; equals col_range combinationally
- rand_gen  output  1  one-cycle request strobe to the LFSR
- rand_in  input  5  random value from the LFSR (range 9..9+col_range-1)
- spawn_valid  output  1  FIFO not empty
- spawn_pos  output  5  FIFO head entry
- spawn_ready  input  1  consumer accepts the head this cycle
- fifo_count  output  3  occupancy, 0..DEPTH
- drop  output  1  one-cycle pulse when a position is discarded because the FIFO is full

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, timer=0, retry=0, last_pos=0, FIFO empty.
  - rand_gen=0, spawn_valid=0, spawn_pos=0, fifo_count=0, drop=0.
- State machine (IDLE, WAIT, REQ, SAMPLE, PUSH):
  - IDLE: if enable=1 go to WAIT, timer=0.
  - WAIT: on tick, timer increments. When tick arrives with timer = max(interval,1)-1, go to REQ and clear timer.
  - REQ: rand_gen=1 for exactly this cycle; next state SAMPLE.
  - SAMPLE: rand_in is captured into cand.
    - If cand==last_pos and retry<MAX_RETRY: retry increments, go to REQ.
    - Otherwise go to PUSH.
  - PUSH: write cand to FIFO, set last_pos=cand, retry=0, go to WAIT.
- Timing: first rand_gen occurs 1 cycle after the terminal tick. Best-case push is 3 cycles after the terminal tick. Each retry adds 2 cycles.
- enable=0:
  - From WAIT, REQ or SAMPLE, go to IDLE at the next edge. Any in-flight candidate is abandoned and retry is cleared.
  - From PUSH, the push completes first, then the FSM goes to IDLE.
  - FIFO contents and last_pos are retained. Popping continues while disabled.
- The tick input is ignored outside WAIT; ticks are not accumulated.
- FIFO:
  - Circular buffer with wrapping read/write pointers of log2(DEPTH) bits and a separate count.
  - Pop occurs when spawn_valid & spawn_ready. spawn_pos shows the head combinationally from the read pointer.
  - Push when not full: accepted.
  - Push when full with a pop in the same cycle: accepted, count unchanged.
  - Push when full with no pop: value discarded, drop=1 for that cycle, last_pos still updated.
  - Pop when empty: ignored.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
- col_range=0: the block does not guard against it. rand_in is unspecified and is pushed as sampled; the consumer is responsible.
- Interval changes take effect at the next terminal-tick comparison; there is no re-sync.

Decomposition:
- Shared package:
  - state encoding constants (ST_IDLE..ST_PUSH, 3 bits)
  - POS_W=5
  - POS_BASE=9 (documented offset of LFSR output)
- Sub-module: spawn_fifo, a parameterised DEPTH x POS_W synchronous FIFO with push/pop/full/empty/count, reset via the same async active-low rst. The FSM and timer stay in spawn_scheduler.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: rst=0 for 1 cycle while timer=3, then rst=1, enable=1.
  - Required: all outputs 0 immediately (asynchronously); timer restarts from 0.
- Pacing:
  - Stimulus: interval=3, tick every 4 cycles, LFSR model returns 12, 15, 9, spawn_ready=1.
  - Required: rand_gen pulses once per 3 ticks, 1 cycle after the 3rd tick. spawn_pos sequence is 12, 15, 9, each valid for 1 cycle.
- Repeat rejection:
  - Stimulus: last_pos=14, model returns 14, 14, 14.
  - Required: 3 rand_gen pulses 2 cycles apart (MAX_RETRY=2), then 14 pushed. With a second scenario returning 14, 11, the value 11 is pushed after 2 pulses.
- FIFO full/drop:
  - Stimulus: spawn_ready=0, interval=1, tick every cycle, values 9, 10, 11, 12, 13.
  - Required: fifo_count reaches 4. The 5th push produces drop=1 for 1 cycle, count stays 4, and the head remains 9.
- Full with simultaneous pop:
  - Stimulus: FIFO full, spawn_ready=1 in the PUSH cycle.
  - Required: no drop, count stays 4, head advances to 10, and 13 is written at the tail.
- Disable mid-request:
  - Stimulus: enable=0 in SAMPLE.
  - Required: IDLE next cycle with nothing pushed. Re-enabling produces the next rand_gen only after a full interval.
